multicycle_borrow_subtractor: RTL and testbench

//  Sequential N-bit subtractor computing diff = a - b - bin, 4 bits per clock.

---
 rtl/subtractor_pkg.sv | 12 +
 rtl/borrow_look_ahead_subtractor_4bit.sv | 40 ++++
 rtl/multicycle_borrow_subtractor.sv | 139 +++++++++++++
 tb/tb_multicycle_borrow_subtractor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pkg.sv
// subtractor_pkg
//   Shared types for the multi-cycle borrow subtractor: nibble width,
//   FSM state encoding and the nibble slice type.
package subtractor_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_e;

    typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/borrow_look_ahead_subtractor_4bit.sv
// borrow_look_ahead_subtractor_4bit
//   Combinational 4-bit subtractor d = a - b - bin with borrow look-ahead.
//   Borrow generate Gb = ~a & b, propagate Pb = ~a | b; every internal
//   borrow is expanded as a flat sum of products rather than rippled.
// Ports
//   a_i     in  4  minuend nibble
//   b_i     in  4  subtrahend nibble
//   bin_i   in  1  borrow-in
//   d_o     out 4  difference nibble
//   bout_o  out 1  borrow-out (B4)
module borrow_look_ahead_subtractor_4bit
    import subtractor_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             bin_i,
    output logic [NIB_W-1:0] d_o,
    output logic             bout_o
);

    logic [NIB_W-1:0] gb;
    logic [NIB_W-1:0] pb;
    logic [NIB_W:0]   bb;

    assign gb = ~a_i & b_i;
    assign pb = ~a_i | b_i;

    assign bb[0] = bin_i;
    assign bb[1] = gb[0] | (pb[0] & bin_i);
    assign bb[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & bin_i);
    assign bb[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                 | (pb[2] & pb[1] & pb[0] & bin_i);
    assign bb[4] = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
                 | (pb[3] & pb[2] & pb[1] & gb[0])
                 | (pb[3] & pb[2] & pb[1] & pb[0] & bin_i);

    assign d_o    = a_i ^ b_i ^ bb[NIB_W-1:0];
    assign bout_o = bb[NIB_W];

endmodule

// File: rtl/multicycle_borrow_subtractor.sv
// multicycle_borrow_subtractor
//   Sequential WIDTH-bit subtractor diff = a - b - bin, one nibble per clock.
//   Operands are captured on an in_valid/in_ready handshake, processed LSB
//   nibble first through a single 4-bit look-ahead slice, and the result is
//   held until an out_valid/out_ready handshake. WIDTH must be a multiple
//   of 4 and at least 8.
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      a/b/bin valid
//   in_ready   out  1      block accepts operands this cycle
//   a, b       in   WIDTH  minuend, subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      diff/bout/overflow valid
//   out_ready  in   1      consumer takes the result
//   diff       out  WIDTH  a - b - bin mod 2^WIDTH
//   bout       out  1      unsigned borrow-out
//   overflow   out  1      two's-complement overflow
module multicycle_borrow_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    sub_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;

    nibble_t          nib_a, nib_b, nib_d;
    logic             nib_bout;

    assign nib_a = a_q[NIB_W*idx_q +: NIB_W];
    assign nib_b = b_q[NIB_W*idx_q +: NIB_W];

    borrow_look_ahead_subtractor_4bit u_nib (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .bin_i  (borrow_q),
        .d_o    (nib_d),
        .bout_o (nib_bout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[NIB_W*idx_q +: NIB_W] = nib_d;
                borrow_d = nib_bout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    bout_d  = nib_bout;
                    // nib_d[MSB] is the final diff sign bit, written this cycle
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (nib_d[NIB_W-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered so in_ready stays low on the reset cycle itself and
        // never depends combinationally on in_valid/out_ready.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            borrow_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            borrow_q   <= borrow_d;
            a_q        <= a_d;
            b_q        <= b_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_multicycle_borrow_subtractor.sv
// tb_multicycle_borrow_subtractor
//   Directed bench for the 16-bit multi-cycle borrow subtractor. Inputs are
//   driven and outputs sampled on the falling edge. Expected results come
//   from a 17-bit arithmetic reference pushed to a scoreboard queue at accept.
module tb_multicycle_borrow_subtractor;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    multicycle_borrow_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        exp_t e;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        e.d  = full[W-1:0];
        e.bo = full[W];
        e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
        return e;
    endfunction

    // Present operands until accepted; leaves us at the negedge after accept.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit push);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        if (push) sb.push_back(model(x, y, c));
        in_valid = 1'b1; a = x; b = y; bin = c;
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_low_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    // Called at the negedge after accept; returns cycles until out_valid.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic recv(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_diff"}, {16'd0, diff}, {16'd0, e.d});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, e.bo});
        chk({tag, "_ovf"},  {31'd0, overflow}, {31'd0, e.ov});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready_back"},  {31'd0, in_ready},  32'd1);
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int lat;
        send(x, y, c, 1'b1);
        wait_out(lat);
        recv(tag);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff",      {16'd0, diff},      32'd0);
        chk("rst_bout",      {31'd0, bout},      32'd0);
        chk("rst_ovf",       {31'd0, overflow},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // 1: basic, with exact latency
        send(16'h1234, 16'h0234, 1'b0, 1'b1);
        wait_out(lat);
        chk("t1_latency", lat, NIB);
        chk("t1_diff_const", {16'd0, diff}, 32'h1000);
        recv("t1");

        // 2..4: borrow ripple, overflow both directions, bin=1
        op("t2", 16'h0000, 16'h0001, 1'b0);
        op("t3a", 16'h8000, 16'h0001, 1'b0);
        op("t3b", 16'h7FFF, 16'hFFFF, 1'b0);
        op("t4", 16'h0005, 16'h0005, 1'b1);

        // 5: backpressure in DONE with ignored in_valid pulses
        send(16'h4321, 16'h1234, 1'b1, 1'b1);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 16'hFFFF - 16'(i);
            b = 16'(i);
            @(negedge clk);
            chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t5_hold_diff", {16'd0, diff}, {16'd0, sb[0].d});
        end
        in_valid = 1'b0;
        recv("t5");

        // 6: reset sampled on the second RUN edge aborts the operation
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_in_ready",  {31'd0, in_ready},  32'd0);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_diff",      {16'd0, diff},      32'd0);
        chk("t6_bout",      {31'd0, bout},      32'd0);
        chk("t6_ovf",       {31'd0, overflow},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_release_in_ready", {31'd0, in_ready}, 32'd1);
        send(16'hABCD, 16'h1111, 1'b0, 1'b1);
        wait_out(lat);
        chk("t6_latency", lat, NIB);
        chk("t6_diff_const", {16'd0, diff}, 32'h9ABC);
        recv("t6");

        // A few random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            op("rnd", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
